// File: rtl/fetch_unit.sv
// Fetch stage: drives the program counter to a combinational instruction memory,
// captures the returned word into an IR and hands it to decode over valid/ready.
module fetch_unit #(
  parameter int INSTRUCTION_WIDTH = 40,
  parameter int PC_WIDTH          = 5,
  parameter int RESET_PC          = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run_i,
  input  logic                         halt_i,
  input  logic                         jump_en_i,
  input  logic [PC_WIDTH-1:0]          jump_addr_i,
  output logic [PC_WIDTH-1:0]          pc_o,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_i,
  output logic [INSTRUCTION_WIDTH-1:0] ir_o,
  output logic [PC_WIDTH-1:0]          ir_pc_o,
  output logic                         ir_valid_o,
  input  logic                         ir_ready_i,
  output logic [1:0]                   state_o
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HALT = 2'b10;

  logic [1:0]                   state_q, state_d;
  logic [PC_WIDTH-1:0]          pc_q, pc_d;
  logic [PC_WIDTH-1:0]          ir_pc_q, ir_pc_d;
  logic [INSTRUCTION_WIDTH-1:0] ir_q, ir_d;
  logic                         ir_valid_q, ir_valid_d;
  logic                         consume, load_ok;

  assign consume = ir_valid_q & ir_ready_i;
  assign load_ok = ~ir_valid_q | ir_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!jump_en_i && run_i) state_d = S_RUN;
      S_RUN: begin
        if (halt_i)         state_d = S_HALT;
        else if (jump_en_i) state_d = S_RUN;
        else if (!run_i)    state_d = S_IDLE;
      end
      S_HALT: if (jump_en_i) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state; a jump always flushes, which also retires any IR in flight.
  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q & ~consume;
    case (state_q)
      S_IDLE: begin
        if (jump_en_i) begin
          pc_d       = jump_addr_i;
          ir_valid_d = 1'b0;
        end
      end
      S_RUN: begin
        if (halt_i) begin
          ir_valid_d = 1'b0;
        end else if (jump_en_i) begin
          pc_d       = jump_addr_i;
          ir_valid_d = 1'b0;
        end else if (run_i && load_ok) begin
          ir_d       = instr_i;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          pc_d       = pc_q + PC_WIDTH'(1);
        end
      end
      S_HALT: begin
        ir_valid_d = 1'b0;
        if (jump_en_i) pc_d = jump_addr_i;
      end
      default: ir_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= PC_WIDTH'(RESET_PC);
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign pc_o       = pc_q;
  assign ir_o       = ir_q;
  assign ir_pc_o    = ir_pc_q;
  assign ir_valid_o = ir_valid_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory model returns mem[k] = k.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_i, halt_i, jump_en_i, ir_ready_i;
  logic [4:0]  jump_addr_i;
  logic [4:0]  pc_o, ir_pc_o;
  logic [39:0] instr_i, ir_o;
  logic        ir_valid_o;
  logic [1:0]  state_o;

  int errs = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  assign instr_i = {35'd0, pc_o};

  fetch_unit #(.INSTRUCTION_WIDTH(40), .PC_WIDTH(5), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .run_i(run_i), .halt_i(halt_i),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i), .pc_o(pc_o),
    .instr_i(instr_i), .ir_o(ir_o), .ir_pc_o(ir_pc_o),
    .ir_valid_o(ir_valid_o), .ir_ready_i(ir_ready_i), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ir(input string tag, input logic [4:0] pc_exp, input logic [4:0] nxt_pc);
    chk({tag, ".valid"}, 40'(ir_valid_o), 40'd1);
    chk({tag, ".ir_pc"}, 40'(ir_pc_o), 40'(pc_exp));
    chk({tag, ".ir"},    ir_o,          40'(pc_exp));
    chk({tag, ".pc"},    40'(pc_o),     40'(nxt_pc));
  endtask

  initial begin
    rst_n = 1'b0; run_i = 1'b0; halt_i = 1'b0; jump_en_i = 1'b0;
    jump_addr_i = 5'd0; ir_ready_i = 1'b0;
    #12;
    chk("rst.pc",    40'(pc_o),       40'd0);
    chk("rst.ir",    ir_o,            40'd0);
    chk("rst.ir_pc", 40'(ir_pc_o),    40'd0);
    chk("rst.valid", 40'(ir_valid_o), 40'd0);
    chk("rst.state", 40'(state_o),    40'd0);
    @(negedge clk); rst_n = 1'b1;

    // Sequential fetch: first valid two edges after run_i
    tick(); run_i = 1'b1; ir_ready_i = 1'b1;
    tick();
    chk("run.state", 40'(state_o),    40'd1);
    chk("run.nov",   40'(ir_valid_o), 40'd0);
    tick(); chk_ir("seq0", 5'd0, 5'd1);
    tick(); chk_ir("seq1", 5'd1, 5'd2);
    tick(); chk_ir("seq2", 5'd2, 5'd3);
    tick(); chk_ir("seq3", 5'd3, 5'd4);
    tick(); chk_ir("seq4", 5'd4, 5'd5);

    // Decode stall for three cycles
    ir_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_ir("stall", 5'd4, 5'd5);
    end
    ir_ready_i = 1'b1;
    tick(); chk_ir("rel5", 5'd5, 5'd6);
    tick(); chk_ir("rel6", 5'd6, 5'd7);

    // Jump while decode is stalled flushes the IR
    ir_ready_i = 1'b0;
    tick(); chk_ir("stall6", 5'd6, 5'd7);
    jump_en_i = 1'b1; jump_addr_i = 5'd20;
    tick();
    chk("jmp.valid", 40'(ir_valid_o), 40'd0);
    chk("jmp.pc",    40'(pc_o),       40'd20);
    jump_en_i = 1'b0; ir_ready_i = 1'b1;
    tick(); chk_ir("jmp20", 5'd20, 5'd21);

    // PC wrap at 31
    jump_en_i = 1'b1; jump_addr_i = 5'd30;
    tick(); chk("j30.pc", 40'(pc_o), 40'd30);
    jump_en_i = 1'b0;
    tick(); chk_ir("w30", 5'd30, 5'd31);
    tick(); chk_ir("w31", 5'd31, 5'd0);
    tick(); chk_ir("w0",  5'd0,  5'd1);
    tick(); chk_ir("w1",  5'd1,  5'd2);

    // Halt beats a simultaneous jump; only a jump leaves HALT
    halt_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 5'd9;
    tick();
    chk("hlt.state", 40'(state_o),    40'd2);
    chk("hlt.valid", 40'(ir_valid_o), 40'd0);
    chk("hlt.pc",    40'(pc_o),       40'd2);
    halt_i = 1'b0; jump_en_i = 1'b0;
    tick();
    chk("hlt2.state", 40'(state_o), 40'd2);
    chk("hlt2.pc",    40'(pc_o),    40'd2);
    jump_en_i = 1'b1; jump_addr_i = 5'd3;
    tick();
    chk("hj.state", 40'(state_o),    40'd1);
    chk("hj.pc",    40'(pc_o),       40'd3);
    chk("hj.valid", 40'(ir_valid_o), 40'd0);
    jump_en_i = 1'b0;
    tick(); chk_ir("hj3", 5'd3, 5'd4);

    // Pause: IR drains in IDLE, no new loads; jump in IDLE stays IDLE
    run_i = 1'b0; ir_ready_i = 1'b0;
    tick();
    chk("pause.state", 40'(state_o), 40'd0);
    chk_ir("pause", 5'd3, 5'd4);
    ir_ready_i = 1'b1;
    tick();
    chk("drain.valid", 40'(ir_valid_o), 40'd0);
    chk("drain.pc",    40'(pc_o),       40'd4);
    jump_en_i = 1'b1; jump_addr_i = 5'd10;
    tick();
    chk("ij.state", 40'(state_o), 40'd0);
    chk("ij.pc",    40'(pc_o),    40'd10);
    jump_en_i = 1'b0; run_i = 1'b1;
    tick();
    chk("rr.state", 40'(state_o),    40'd1);
    chk("rr.valid", 40'(ir_valid_o), 40'd0);
    tick(); chk_ir("rr10", 5'd10, 5'd11);

    // Asynchronous reset between edges
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst.pc",    40'(pc_o),       40'd0);
    chk("arst.valid", 40'(ir_valid_o), 40'd0);
    chk("arst.state", 40'(state_o),    40'd0);
    #10 rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
